// File: rtl/opacc_pkg.sv
// Shared types and defaults for the opacc tile sequencer.
package opacc_pkg;

    localparam int OPACC_ML = 4;
    localparam int OPACC_KW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SWAP = 2'd1,
        MAC  = 2'd2
    } opacc_seq_st_t;

endpackage

// File: rtl/opacc_seq_if.sv
// Handshake bundle between MPU issue logic, the opacc array and the sequencer.
//
// Handshake rule for every valid/ready pair on this bundle (cmd, c, ab, o):
// a transfer happens in exactly the cycle where valid and ready are both high
// at the rising clock edge. valid never waits for ready. Once raised, a
// producer holds valid and its payload until the transfer happens.
interface opacc_seq_if
    import opacc_pkg::*;
#(
    parameter int KW = OPACC_KW
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [KW-1:0] cmd_k;
    logic          cmd_first;
    logic          cmd_flush;

    logic          c_valid;
    logic          c_ready;
    logic          c_zero;

    logic          ab_valid;
    logic          ab_ready;

    logic          en_c;
    logic          en_ab;

    logic          o_valid;
    logic          o_last;
    logic          o_ready;

    logic          tile_done;
    logic          busy;
    opacc_seq_st_t state_dbg;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_k, cmd_first, cmd_flush, c_valid, ab_valid, o_ready,
        output cmd_ready, c_ready, c_zero, ab_ready, en_c, en_ab,
        output o_valid, o_last, tile_done, busy, state_dbg
    );

    // Issue logic / stream sources / result sink side.
    modport master (
        output cmd_valid, cmd_k, cmd_first, cmd_flush, c_valid, ab_valid, o_ready,
        input  cmd_ready, c_ready, c_zero, ab_ready, en_c, en_ab,
        input  o_valid, o_last, tile_done, busy, state_dbg
    );

endinterface

// File: rtl/opacc_seq.sv
// Tile sequencer for the opacc outer-product accumulator: a SWAP phase that
// shifts ML C rows in (popping the previous results out), then K MAC steps.
module opacc_seq
    import opacc_pkg::*;
#(
    parameter int ML = OPACC_ML,
    parameter int KW = OPACC_KW
) (
    input  logic       clk,
    input  logic       rst,
    opacc_seq_if.slave bus
);

    localparam int RW = (ML > 1) ? $clog2(ML) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ML - 1);

    opacc_seq_st_t state_q, state_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic          first_q, first_d;
    logic          flush_q, flush_d;
    logic          o_valid_q, o_valid_d;
    logic          o_last_q, o_last_d;
    logic          done_q, done_d;
    logic          c_zero_q, c_zero_d;

    logic          slot_free;
    logic          cmd_ready_c, c_ready_c, ab_ready_c, en_c_c, en_ab_c;
    logic          row_last;

    // Next-state, strobes and stream readiness for the IDLE/SWAP/MAC sequence.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        k_d         = k_q;
        first_d     = first_q;
        flush_d     = flush_q;
        done_d      = 1'b0;
        cmd_ready_c = 1'b0;
        c_ready_c   = 1'b0;
        ab_ready_c  = 1'b0;
        en_c_c      = 1'b0;
        en_ab_c     = 1'b0;
        // A new row may only be popped when the output slot is empty or draining now.
        slot_free   = !o_valid_q || bus.o_ready;
        row_last    = (row_cnt_q == ROW_LAST);
        case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    k_d       = bus.cmd_k;
                    first_d   = bus.cmd_first;
                    flush_d   = bus.cmd_flush;
                    row_cnt_d = '0;
                    state_d   = SWAP;
                end
            end
            SWAP: begin
                c_ready_c = slot_free && !flush_q;
                // A flush shifts zeros in, so it needs no C stream data.
                en_c_c    = flush_q ? slot_free : (bus.c_valid && c_ready_c);
                if (en_c_c) begin
                    row_cnt_d = row_last ? '0 : row_cnt_q + RW'(1);
                    if (row_last) begin
                        if (!flush_q && (k_q != '0)) begin
                            state_d = MAC;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            MAC: begin
                ab_ready_c = 1'b1;
                en_ab_c    = bus.ab_valid;
                if (en_ab_c) begin
                    if (k_q != '0) k_d = k_q - KW'(1);
                    if (k_q == KW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result-row flags: a popped row is visible the cycle after en_c (opacc registers vo_c).
    always_comb begin
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        if (en_c_c && !first_q) begin
            o_valid_d = 1'b1;
            o_last_d  = row_last;
        end else if (bus.o_ready) begin
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
        end
        c_zero_d = (state_d == SWAP) && flush_d;
    end

    // State register; reset may arrive mid-tile and abandons the array contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            k_q       <= '0;
            first_q   <= 1'b0;
            flush_q   <= 1'b0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            done_q    <= 1'b0;
            c_zero_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            k_q       <= k_d;
            first_q   <= first_d;
            flush_q   <= flush_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            done_q    <= done_d;
            c_zero_q  <= c_zero_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.c_ready   = c_ready_c;
    assign bus.ab_ready  = ab_ready_c;
    assign bus.en_c      = en_c_c;
    assign bus.en_ab     = en_ab_c;
    assign bus.c_zero    = c_zero_q;
    assign bus.o_valid   = o_valid_q;
    assign bus.o_last    = o_valid_q && o_last_q;
    assign bus.tile_done = done_q;
    assign bus.busy      = (state_q != IDLE) || o_valid_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_opacc_seq.sv
// Directed bench for opacc_seq: each task runs one scenario with a fixed cycle
// window and compares recorded strobe patterns against hand-derived values.
module tb_opacc_seq;
    import opacc_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    opacc_seq_if #(.KW(16)) bus ();

    opacc_seq #(.ML(4), .KW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_k     = '0;
        bus.cmd_first = 1'b0;
        bus.cmd_flush = 1'b0;
        bus.c_valid   = 1'b0;
        bus.ab_valid  = 1'b0;
        bus.o_ready   = 1'b1;
    endtask

    // Present one command in IDLE for one cycle; returns just after the accepting edge.
    task automatic issue_cmd(input logic [15:0] k, input logic first, input logic flush);
        bus.cmd_valid = 1'b1;
        bus.cmd_k     = k;
        bus.cmd_first = first;
        bus.cmd_flush = flush;
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_cmd_ready: got %b want 1", bus.cmd_ready);
        end
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.en_c, bus.en_ab, bus.o_valid, bus.o_last,
             bus.tile_done, bus.busy, bus.c_zero, bus.c_ready, bus.ab_ready} !== 10'b10_0000_0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 1000000000",
                     {bus.cmd_ready, bus.en_c, bus.en_ab, bus.o_valid, bus.o_last,
                      bus.tile_done, bus.busy, bus.c_zero, bus.c_ready, bus.ab_ready});
        end
        n_checks++;
        if (bus.state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, IDLE);
        end
        cyc();
    endtask

    task automatic test_rst_mid_mac();
        int n_ab;
        n_ab = 0;
        drive_idle();
        bus.c_valid  = 1'b1;
        bus.ab_valid = 1'b1;
        issue_cmd(16'd8, 1'b1, 1'b0);
        // Cycles 0..3 shift rows, 4..6 are three MAC steps.
        for (int c = 0; c < 7; c++) begin
            #1;
            if (bus.en_ab === 1'b1) n_ab++;
            cyc();
        end
        #1;
        n_checks++;
        if (n_ab !== 3 || bus.state_dbg !== MAC) begin
            n_fail++;
            $display("FAIL mid_mac_setup: en_ab=%0d state=%0d want 3 and %0d", n_ab, bus.state_dbg, MAC);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.en_ab, bus.o_valid, bus.busy} !== 4'b1000 || bus.state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL mid_mac_reset: cmd_ready/en_ab/o_valid/busy=%b state=%0d want 1000 and IDLE",
                     {bus.cmd_ready, bus.en_ab, bus.o_valid, bus.busy}, bus.state_dbg);
        end
        drive_idle();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_first_mac();
        logic [11:0] ec_v, eab_v, td_v, ov_v;
        ec_v = '0; eab_v = '0; td_v = '0; ov_v = '0;
        drive_idle();
        bus.c_valid  = 1'b1;
        bus.ab_valid = 1'b1;
        issue_cmd(16'd3, 1'b1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            #1;
            ec_v[c]  = bus.en_c;
            eab_v[c] = bus.en_ab;
            td_v[c]  = bus.tile_done;
            ov_v[c]  = bus.o_valid;
            cyc();
        end
        n_checks++;
        if (ec_v !== 12'h00F) begin
            n_fail++;
            $display("FAIL first_en_c: got %h want 00f", ec_v);
        end
        n_checks++;
        if (eab_v !== 12'h070) begin
            n_fail++;
            $display("FAIL first_en_ab: got %h want 070", eab_v);
        end
        n_checks++;
        if (td_v !== 12'h080) begin
            n_fail++;
            $display("FAIL first_tile_done: got %h want 080", td_v);
        end
        n_checks++;
        if (ov_v !== 12'h000) begin
            n_fail++;
            $display("FAIL first_no_o_valid: got %h want 000", ov_v);
        end
        drive_idle();
    endtask

    task automatic test_swap_stall();
        logic [9:0] ec_v, td_v, eab_v;
        logic [3:0] last_v;
        int         n_hs;
        ec_v = '0; td_v = '0; eab_v = '0; last_v = '0; n_hs = 0;
        drive_idle();
        bus.c_valid = 1'b1;
        issue_cmd(16'd0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            bus.o_ready = !(c == 1 || c == 2);
            #1;
            ec_v[c]  = bus.en_c;
            td_v[c]  = bus.tile_done;
            eab_v[c] = bus.en_ab;
            if (bus.o_valid && bus.o_ready) begin
                if (n_hs < 4) last_v[n_hs] = bus.o_last;
                n_hs++;
            end
            cyc();
        end
        n_checks++;
        if (ec_v !== 10'b00_0011_1001) begin
            n_fail++;
            $display("FAIL stall_en_c: got %b want 0000111001", ec_v);
        end
        n_checks++;
        if (n_hs !== 4 || last_v !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_rows: rows=%0d last=%b want 4 and 1000", n_hs, last_v);
        end
        n_checks++;
        if (td_v !== 10'b00_0100_0000 || eab_v !== '0) begin
            n_fail++;
            $display("FAIL stall_done: tile_done=%b en_ab=%b want 0001000000 and 0", td_v, eab_v);
        end
        drive_idle();
    endtask

    task automatic test_flush();
        logic [9:0] ec_v, cz_v, td_v, cr_v, eab_v;
        logic [3:0] last_v;
        int         n_hs;
        ec_v = '0; cz_v = '0; td_v = '0; cr_v = '0; eab_v = '0; last_v = '0; n_hs = 0;
        drive_idle();
        bus.c_valid  = 1'b1;
        bus.ab_valid = 1'b1;
        issue_cmd(16'd5, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            #1;
            ec_v[c]  = bus.en_c;
            cz_v[c]  = bus.c_zero;
            td_v[c]  = bus.tile_done;
            cr_v[c]  = bus.c_ready;
            eab_v[c] = bus.en_ab;
            if (bus.o_valid && bus.o_ready) begin
                if (n_hs < 4) last_v[n_hs] = bus.o_last;
                n_hs++;
            end
            cyc();
        end
        n_checks++;
        if (ec_v !== 10'h00F || cz_v !== 10'h00F) begin
            n_fail++;
            $display("FAIL flush_en_c_zero: en_c=%h c_zero=%h want 00f 00f", ec_v, cz_v);
        end
        n_checks++;
        if (cr_v !== '0 || eab_v !== '0) begin
            n_fail++;
            $display("FAIL flush_no_consume: c_ready=%h en_ab=%h want 0 0", cr_v, eab_v);
        end
        n_checks++;
        if (n_hs !== 4 || last_v !== 4'b1000 || td_v !== 10'h010) begin
            n_fail++;
            $display("FAIL flush_drain: rows=%0d last=%b done=%h want 4 1000 010", n_hs, last_v, td_v);
        end
        drive_idle();
    endtask

    task automatic test_ab_toggle();
        logic [11:0] ec_v, eab_v, td_v;
        logic        ab_rdy_seen;
        ec_v = '0; eab_v = '0; td_v = '0; ab_rdy_seen = 1'b0;
        drive_idle();
        bus.c_valid = 1'b1;
        issue_cmd(16'd2, 1'b1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            bus.ab_valid = (c == 4 || c == 6);
            #1;
            ec_v[c]  = bus.en_c;
            eab_v[c] = bus.en_ab;
            td_v[c]  = bus.tile_done;
            if (c == 5) ab_rdy_seen = bus.ab_ready;
            cyc();
        end
        n_checks++;
        if (eab_v !== 12'h050 || ab_rdy_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_en_ab: en_ab=%h ab_ready@5=%b want 050 1", eab_v, ab_rdy_seen);
        end
        n_checks++;
        if (ec_v !== 12'h00F || td_v !== 12'h080) begin
            n_fail++;
            $display("FAIL toggle_en_c_done: en_c=%h done=%h want 00f 080", ec_v, td_v);
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ec_v, td_v;
        logic [7:0]  last_v;
        logic [4:0]  snap4, snap6;
        int          n_hs;
        ec_v = '0; td_v = '0; last_v = '0; n_hs = 0; snap4 = '0; snap6 = '0;
        drive_idle();
        bus.c_valid = 1'b1;
        issue_cmd(16'd0, 1'b0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            bus.cmd_valid = (c == 4);
            bus.cmd_k     = '0;
            bus.cmd_first = 1'b0;
            bus.cmd_flush = 1'b0;
            bus.o_ready   = !(c >= 4 && c <= 7);
            #1;
            ec_v[c] = bus.en_c;
            td_v[c] = bus.tile_done;
            if (c == 4) snap4 = {bus.cmd_ready, bus.o_valid, bus.o_last, bus.busy, bus.en_c};
            if (c == 6) snap6 = {bus.state_dbg == SWAP, bus.o_valid, bus.o_last, bus.c_ready, bus.en_c};
            if (bus.o_valid && bus.o_ready) begin
                if (n_hs < 8) last_v[n_hs] = bus.o_last;
                n_hs++;
            end
            cyc();
        end
        n_checks++;
        if (snap4 !== 5'b11110) begin
            n_fail++;
            $display("FAIL b2b_accept: cmd_ready/o_valid/o_last/busy/en_c=%b want 11110", snap4);
        end
        n_checks++;
        if (snap6 !== 5'b11100) begin
            n_fail++;
            $display("FAIL b2b_stall: swap/o_valid/o_last/c_ready/en_c=%b want 11100", snap6);
        end
        n_checks++;
        if (ec_v !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL b2b_en_c: got %h want 0f0f", ec_v);
        end
        n_checks++;
        if (td_v !== 16'h1010 || n_hs !== 8 || last_v !== 8'b1000_1000) begin
            n_fail++;
            $display("FAIL b2b_rows: done=%h rows=%0d last=%b want 1010 8 10001000", td_v, n_hs, last_v);
        end
        drive_idle();
    endtask

    // Scenario sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        test_reset();
        test_rst_mid_mac();
        test_first_mac();
        test_swap_stall();
        test_flush();
        test_ab_toggle();
        test_back_to_back();
        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
